// File: rtl/lpc_model_collector.sv
// Triangular store for Levinson-Durbin coefficients with a 1-cycle random-access read port; no backpressure, iEnable freezes all state.
// Define PROTOCOL_CHECK_EN to add burst checking and the sticky S_ERROR state; otherwise oError is tied low.
module lpc_model_collector #(
    parameter int ORDER = 12,
    parameter int DW    = 32
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iEnable,
    input  logic [3:0]        iM,
    input  logic [DW-1:0]     iModel,
    input  logic              iValid,
    input  logic              iDone,
    input  logic              iReadEn,
    input  logic [3:0]        iReadOrder,
    input  logic [3:0]        iReadIndex,
    output logic [DW-1:0]     oReadData,
    output logic              oReadValid,
    output logic [ORDER-1:0]  oOrderValid,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError
);
    localparam int DEPTH = ORDER * (ORDER + 1) / 2;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [3:0] ORDER_L = 4'(ORDER);

`ifdef PROTOCOL_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;
`endif

    // base(m) = m*(m-1)/2 as a table so no multiplier is inferred
    function automatic logic [6:0] base_of(input logic [3:0] m);
        case (m)
            4'd2:    return 7'd1;
            4'd3:    return 7'd3;
            4'd4:    return 7'd6;
            4'd5:    return 7'd10;
            4'd6:    return 7'd15;
            4'd7:    return 7'd21;
            4'd8:    return 7'd28;
            4'd9:    return 7'd36;
            4'd10:   return 7'd45;
            4'd11:   return 7'd55;
            4'd12:   return 7'd66;
            4'd13:   return 7'd78;
            4'd14:   return 7'd91;
            4'd15:   return 7'd105;
            default: return 7'd0;
        endcase
    endfunction

    function automatic logic [7:0] addr_of(input logic [3:0] m, input logic [3:0] j);
        return {1'b0, base_of(m)} + {4'b0, j} - 8'd1;
    endfunction

    logic [DW-1:0]    mem [DEPTH];
    state_t           state_q;
    logic [3:0]       ml_q, cnt_q;
    logic [ORDER-1:0] orderv_q;
    logic             busy_q, done_q;
    logic [DW-1:0]    rd_data_q;
    logic             rd_vld_q;
`ifdef PROTOCOL_CHECK_EN
    logic [3:0]       last_q;
    logic             err_q;
`endif

    logic        start_ok, wr_en, rd_ok;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] ov16;

    always_comb begin
        start_ok = (iM != 4'd0) && (iM <= ORDER_L);
`ifdef PROTOCOL_CHECK_EN
        start_ok = start_ok && (iM == last_q + 4'd1);
`endif
        wr_en   = 1'b0;
        wr_addr = 8'd0;
        if (state_q == S_IDLE && iValid && start_ok) begin
            wr_en   = 1'b1;
            wr_addr = addr_of(iM, iM);
        end else if (state_q == S_CAPTURE && iValid && cnt_q < ml_q) begin
            wr_en   = 1'b1;
`ifdef PROTOCOL_CHECK_EN
            wr_en   = (iM == ml_q);
`endif
            wr_addr = addr_of(ml_q, ml_q - cnt_q);
        end

        // An order whose burst is still landing reads as zero even if its bit is set
        ov16    = 16'(orderv_q);
        rd_addr = addr_of(iReadOrder, iReadIndex);
        rd_ok   = iReadEn && (iReadOrder != 4'd0) && (iReadOrder <= ORDER_L)
                  && ov16[iReadOrder - 4'd1]
                  && (iReadIndex != 4'd0) && (iReadIndex <= iReadOrder)
                  && !(busy_q && ml_q == iReadOrder);
    end

    always_ff @(posedge iClock) begin
        if (iEnable && !iReset && wr_en) begin
            mem[wr_addr[AW-1:0]] <= iModel;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            ml_q      <= 4'd0;
            cnt_q     <= 4'd0;
            orderv_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
`ifdef PROTOCOL_CHECK_EN
            last_q    <= 4'd0;
            err_q     <= 1'b0;
`endif
        end else if (iEnable) begin
            rd_vld_q  <= iReadEn;
            rd_data_q <= rd_ok ? mem[rd_addr[AW-1:0]] : '0;
            case (state_q)
                S_IDLE: begin
                    if (iValid) begin
                        if (start_ok) begin
                            ml_q    <= iM;
                            cnt_q   <= 4'd1;
                            busy_q  <= 1'b1;
                            state_q <= S_CAPTURE;
                        end
`ifdef PROTOCOL_CHECK_EN
                        else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERROR;
                        end
`endif
                    end else if (iDone) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_CAPTURE: begin
                    if (iValid) begin
`ifdef PROTOCOL_CHECK_EN
                        if (iM != ml_q || cnt_q >= ml_q) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_ERROR;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
`else
                        if (cnt_q < ml_q) cnt_q <= cnt_q + 4'd1;
`endif
                    end else begin
                        busy_q <= 1'b0;
`ifdef PROTOCOL_CHECK_EN
                        if (cnt_q != ml_q) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERROR;
                        end else begin
                            orderv_q[ml_q - 4'd1] <= 1'b1;
                            last_q  <= ml_q;
                            done_q  <= iDone;
                            state_q <= iDone ? S_DONE : S_IDLE;
                        end
`else
                        orderv_q[ml_q - 4'd1] <= 1'b1;
                        done_q  <= iDone;
                        state_q <= iDone ? S_DONE : S_IDLE;
`endif
                    end
                end
                S_DONE: begin
`ifdef PROTOCOL_CHECK_EN
                    if (iValid) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign oReadData   = rd_data_q;
    assign oReadValid  = rd_vld_q;
    assign oOrderValid = orderv_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;
`ifdef PROTOCOL_CHECK_EN
    assign oError      = err_q;
`else
    assign oError      = 1'b0;
`endif
endmodule

// File: tb/tb_lpc_model_collector.sv
// Bench for lpc_model_collector: fixed vectors, hand sequences and a random capture/read pass against a store model.
module tb_lpc_model_collector;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        iReset, iEnable, iValid, iDone, iReadEn;
    logic [3:0]  iM, iReadOrder, iReadIndex;
    logic [31:0] iModel, oReadData;
    logic        oReadValid, oBusy, oDone, oError;
    logic [11:0] oOrderValid;

    lpc_model_collector dut (
        .iClock(clk), .iReset(iReset), .iEnable(iEnable), .iM(iM), .iModel(iModel),
        .iValid(iValid), .iDone(iDone), .iReadEn(iReadEn), .iReadOrder(iReadOrder),
        .iReadIndex(iReadIndex), .oReadData(oReadData), .oReadValid(oReadValid),
        .oOrderValid(oOrderValid), .oBusy(oBusy), .oDone(oDone), .oError(oError)
    );

    int errors = 0;
    int checks = 0;

    // Model: coefficient a_m[j] lives at mm[m][j]; mv[m] marks a captured order
    logic [31:0] mm [16][16];
    bit          mv [16];
    bit          burst_on = 1'b0;
    int          burst_m  = 0;

    typedef struct {
        int          o;
        int          i;
        logic [31:0] exp;
    } rvec_t;
    rvec_t tv [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input int m, input int j);
        return 32'((m << 8) | j);
    endfunction

    task automatic do_reset();
        iReset = 1'b1; iEnable = 1'b1; iValid = 1'b0; iDone = 1'b0; iReadEn = 1'b0;
        iM = 4'd0; iModel = 32'd0; iReadOrder = 4'd0; iReadIndex = 4'd0;
        tick(); tick();
        chk("rst_rdata", oReadData, 32'd0);
        chk("rst_rvld",  32'(oReadValid), 32'd0);
        chk("rst_ov",    32'(oOrderValid), 32'd0);
        chk("rst_busy",  32'(oBusy), 32'd0);
        chk("rst_done",  32'(oDone), 32'd0);
        chk("rst_err",   32'(oError), 32'd0);
        iReset = 1'b0;
        for (int k = 0; k < 16; k++) mv[k] = 1'b0;
        burst_on = 1'b0;
    endtask

    // nw words for order m, optional iEnable gap of gap_len cycles before word gap_at, then closing cycle
    task automatic burst(input int m, input int nw, input bit rnd, input int gap_at, input int gap_len);
        logic [31:0] w;
        for (int k = 0; k < nw; k++) begin
            w = rnd ? $urandom : enc(m, m - k);
            iValid = 1'b1; iM = 4'(m); iModel = w;
            if (k == gap_at) begin
                iEnable = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    if (k > 0) chk("busy_gap", 32'(oBusy), 32'd1);
                end
                iEnable = 1'b1;
            end
            tick();
            if (k < m) mm[m][m - k] = w;
        end
        iValid = 1'b0;
        tick();
        if (nw > 0) mv[m] = 1'b1;
    endtask

    task automatic rd_const(input int o, input int i, input logic [31:0] e, input string nm);
        iReadEn = 1'b1; iReadOrder = 4'(o); iReadIndex = 4'(i);
        tick();
        iReadEn = 1'b0;
        chk({nm, "_vld"}, 32'(oReadValid), 32'd1);
        chk(nm, oReadData, e);
    endtask

    task automatic rd(input int o, input int i, input string nm);
        logic [31:0] e;
        e = 32'd0;
        if (o >= 1 && o <= 12 && i >= 1 && i <= o && mv[o] && !(burst_on && burst_m == o))
            e = mm[o][i];
        rd_const(o, i, e, nm);
    endtask

    initial begin
        tv[0] = '{7, 3, 32'h0000_0703};
        tv[1] = '{12, 12, 32'h0000_0C0C};
        tv[2] = '{1, 1, 32'h0000_0101};
        tv[3] = '{12, 1, 32'h0000_0C01};
        tv[4] = '{9, 5, 32'h0000_0905};
        tv[5] = '{0, 1, 32'h0};
        tv[6] = '{13, 1, 32'h0};
        tv[7] = '{5, 6, 32'h0};
        tv[8] = '{5, 0, 32'h0};
        tv[9] = '{15, 15, 32'h0};

        do_reset();

        // Read guards with orders 1..3 captured
        for (int m = 1; m <= 3; m++) burst(m, m, 1'b0, -1, 0);
        chk("ov_123", 32'(oOrderValid), 32'h7);
        rd_const(4, 1, 32'h0, "guard_41");
        rd_const(3, 0, 32'h0, "guard_30");
        rd_const(3, 4, 32'h0, "guard_34");
        rd_const(2, 2, 32'h0000_0202, "guard_22");

        // Nominal to order 12, then iDone
        iValid = 1'b1; iM = 4'd4; iModel = enc(4, 4);
        tick();
        chk("busy_start", 32'(oBusy), 32'd1);
        iModel = enc(4, 3); tick();
        iModel = enc(4, 2); tick();
        iModel = enc(4, 1); tick();
        iValid = 1'b0; tick();
        chk("busy_end", 32'(oBusy), 32'd0);
        for (int m = 5; m <= 12; m++) burst(m, m, 1'b0, -1, 0);
        iDone = 1'b1; tick(); iDone = 1'b0;
        chk("done", 32'(oDone), 32'd1);
        chk("ov_all", 32'(oOrderValid), 32'hFFF);
        for (int t = 0; t < 10; t++) rd_const(tv[t].o, tv[t].i, tv[t].exp, $sformatf("tbl%0d", t));

        // Burst after done must not land
        iValid = 1'b1; iM = 4'd1; iModel = 32'hDEAD_BEEF; tick();
        iValid = 1'b0; tick();
`ifdef PROTOCOL_CHECK_EN
        chk("err_after_done", 32'(oError), 32'd1);
`else
        chk("err_after_done", 32'(oError), 32'd0);
`endif
        rd_const(1, 1, 32'h0000_0101, "rd_after_done");

        // Reset on cycle 3 of the order-5 burst
        do_reset();
        for (int m = 1; m <= 4; m++) burst(m, m, 1'b0, -1, 0);
        iValid = 1'b1; iM = 4'd5; iModel = enc(5, 5); tick();
        iModel = enc(5, 4); tick();
        iModel = enc(5, 3); iReset = 1'b1; tick();
        chk("mrst_ov",   32'(oOrderValid), 32'd0);
        chk("mrst_busy", 32'(oBusy), 32'd0);
        chk("mrst_done", 32'(oDone), 32'd0);
        chk("mrst_err",  32'(oError), 32'd0);
        chk("mrst_rvld", 32'(oReadValid), 32'd0);
        iReset = 1'b0; iValid = 1'b0;
        for (int k = 0; k < 16; k++) mv[k] = 1'b0;
        tick();
        burst(1, 1, 1'b0, -1, 0);
        chk("mrst_ov1", 32'(oOrderValid), 32'h1);
        rd_const(1, 1, 32'h0000_0101, "mrst_rd11");

        // iEnable gap inside order-6 burst
        for (int m = 2; m <= 5; m++) burst(m, m, 1'b0, -1, 0);
        burst(6, 6, 1'b0, 2, 4);
        chk("gap_ov", 32'(oOrderValid), 32'h3F);
        for (int j = 1; j <= 6; j++) rd_const(6, j, enc(6, j), $sformatf("gap_rd6_%0d", j));

        // Random data, random enable gaps, random reads against the model
        do_reset();
        for (int m = 1; m <= 12; m++) begin
            burst(m, m, 1'b1, int'($urandom_range(0, 2 * m)), int'($urandom_range(1, 3)));
            iValid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            for (int r = 0; r < 3; r++)
                rd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rnd");
        end
        for (int o = 1; o <= 12; o++)
            for (int j = 1; j <= o; j++) rd(o, j, $sformatf("sweep_%0d_%0d", o, j));

`ifndef PROTOCOL_CHECK_EN
        // Re-capture of order 5; a read during the burst returns 0
        burst_on = 1'b1; burst_m = 5;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] w;
            w = $urandom;
            iValid = 1'b1; iM = 4'd5; iModel = w;
            if (k == 2) begin iReadEn = 1'b1; iReadOrder = 4'd5; iReadIndex = 4'd1; end
            tick();
            iReadEn = 1'b0;
            mm[5][5 - k] = w;
            if (k == 2) begin
                chk("inburst_vld", 32'(oReadValid), 32'd1);
                chk("inburst_dat", oReadData, 32'd0);
            end
        end
        iValid = 1'b0; tick();
        burst_on = 1'b0;
        chk("recap_ov", 32'(oOrderValid), 32'hFFF);
        for (int j = 1; j <= 5; j++) rd(5, j, "recap");
`endif

        // Short order-4 burst, then order 5
        do_reset();
        for (int m = 1; m <= 3; m++) burst(m, m, 1'b0, -1, 0);
        burst(4, 3, 1'b0, -1, 0);
`ifdef PROTOCOL_CHECK_EN
        chk("short_err", 32'(oError), 32'd1);
        chk("short_ov4", 32'(oOrderValid[3]), 32'd0);
`else
        chk("short_err", 32'(oError), 32'd0);
        chk("short_ov4", 32'(oOrderValid[3]), 32'd1);
`endif
        burst(5, 5, 1'b0, -1, 0);
`ifdef PROTOCOL_CHECK_EN
        chk("after_short_ov5", 32'(oOrderValid[4]), 32'd0);
`else
        chk("after_short_ov5", 32'(oOrderValid[4]), 32'd1);
        rd_const(5, 2, 32'h0000_0502, "after_short_rd52");
`endif

        // Skipped order: 2 captured, then iM = 4
        do_reset();
        burst(1, 1, 1'b0, -1, 0);
        burst(2, 2, 1'b0, -1, 0);
        burst(4, 4, 1'b0, -1, 0);
`ifdef PROTOCOL_CHECK_EN
        chk("skip_err", 32'(oError), 32'd1);
`else
        chk("skip_err", 32'(oError), 32'd0);
`endif
        rd_const(2, 1, 32'h0000_0201, "skip_rd21");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
